// File: rtl/npc_bus_pkg.sv
// Shared types for the NPC memory bus: widths, master ids, arbiter states and
// the latched request payload.
package npc_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef logic mid_t;
  localparam mid_t MID_IFU = 1'b0;
  localparam mid_t MID_LSU = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
    logic              wen;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Valid/ready request + response channel used for the IFU, LSU and memory ports.
// The IFU leaves the write fields tied off.
interface mem_arbiter_if;
  import npc_bus_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              req_wen;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;

  modport master (
    output req_valid, req_addr, req_wdata, req_wmask, req_wen, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wmask, req_wen, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between IFU and LSU requests.
// MEM_ARB_RR_EN: ties go to the master that did not win last; otherwise LSU wins ties.
module mem_arb_pick
  import npc_bus_pkg::*;
(
  input  logic ifu_valid_i,
  input  logic lsu_valid_i,
`ifdef MEM_ARB_RR_EN
  input  mid_t last_i,
`endif
  output logic any_o,
  output mid_t win_o
);

  always_comb begin
    any_o = ifu_valid_i | lsu_valid_i;
    win_o = MID_IFU;
    if (ifu_valid_i && lsu_valid_i) begin
`ifdef MEM_ARB_RR_EN
      win_o = (last_i == MID_IFU) ? MID_LSU : MID_IFU;
`else
      win_o = MID_LSU;
`endif
    end else if (lsu_valid_i) begin
      win_o = MID_LSU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between IFU and LSU with one transaction in flight.
// Tie policy: fixed LSU priority by default, round-robin when MEM_ARB_RR_EN is defined.
module mem_arbiter
  import npc_bus_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  ifu,
  mem_arbiter_if.slave  lsu,
  mem_arbiter_if.master mem,
  output logic          busy
);

  arb_state_e state_q, state_d;
  mid_t       own_q, own_d;
  mem_req_t   req_q, req_d;
  logic       busy_q;
  logic       mreq_valid_q;
  logic       pick_any_c;
  mid_t       pick_win_c;
  logic       resp_hs_c;
`ifdef MEM_ARB_RR_EN
  mid_t       last_q, last_d;
`endif

  // IFU is read-only; its write fields are never looked at.
  logic unused_ifu_fields;
  assign unused_ifu_fields = ^{ifu.req_wdata, ifu.req_wmask, ifu.req_wen};

  mem_arb_pick u_pick (
    .ifu_valid_i (ifu.req_valid),
    .lsu_valid_i (lsu.req_valid),
`ifdef MEM_ARB_RR_EN
    .last_i      (last_q),
`endif
    .any_o       (pick_any_c),
    .win_o       (pick_win_c)
  );

  assign mem.req_valid = mreq_valid_q;
  assign mem.req_addr  = req_q.addr;
  assign mem.req_wdata = req_q.wdata;
  assign mem.req_wmask = req_q.wmask;
  assign mem.req_wen   = req_q.wen;
  assign busy          = busy_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      own_q        <= MID_IFU;
      req_q        <= '0;
      busy_q       <= 1'b0;
      mreq_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      own_q        <= own_d;
      req_q        <= req_d;
      busy_q       <= (state_d != ST_IDLE);
      mreq_valid_q <= (state_d == ST_REQ);
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= MID_IFU;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_comb begin
    state_d         = state_q;
    own_d           = own_q;
    req_d           = req_q;
`ifdef MEM_ARB_RR_EN
    last_d          = last_q;
`endif
    resp_hs_c       = 1'b0;
    ifu.req_ready   = 1'b0;
    lsu.req_ready   = 1'b0;
    ifu.resp_valid  = 1'b0;
    lsu.resp_valid  = 1'b0;
    ifu.resp_data   = '0;
    lsu.resp_data   = '0;
    mem.resp_ready  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any_c) begin
          own_d   = pick_win_c;
          state_d = ST_REQ;
          if (pick_win_c == MID_LSU) begin
            lsu.req_ready = 1'b1;
            req_d = '{addr: lsu.req_addr, wdata: lsu.req_wdata,
                      wmask: lsu.req_wmask, wen: lsu.req_wen};
          end else begin
            ifu.req_ready = 1'b1;
            req_d = '{addr: ifu.req_addr, wdata: '0, wmask: '0, wen: 1'b0};
          end
        end
      end
      ST_REQ: begin
        if (mem.req_ready) state_d = ST_RESP;
      end
      ST_RESP: begin
        // Response channel is a straight pass-through to the owner only.
        if (own_q == MID_LSU) begin
          mem.resp_ready = lsu.resp_ready;
          lsu.resp_valid = mem.resp_valid;
          lsu.resp_data  = mem.resp_data;
          resp_hs_c      = mem.resp_valid && lsu.resp_ready;
        end else begin
          mem.resp_ready = ifu.resp_ready;
          ifu.resp_valid = mem.resp_valid;
          ifu.resp_data  = mem.resp_data;
          resp_hs_c      = mem.resp_valid && ifu.resp_ready;
        end
        if (resp_hs_c) begin
          state_d = ST_IDLE;
`ifdef MEM_ARB_RR_EN
          last_d  = own_q;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: driver tasks queue expected transactions,
// a cycle model pops them at grant time and checks the memory and response sides.
module tb_mem_arbiter;
  import npc_bus_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wen;
    logic [31:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  mem_arbiter_if ifu_if ();
  mem_arbiter_if lsu_if ();
  mem_arbiter_if mem_if ();

  mem_arbiter dut (
    .clk  (clk),
    .rst  (rst),
    .ifu  (ifu_if),
    .lsu  (lsu_if),
    .mem  (mem_if),
    .busy (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] base_word(input logic [31:0] a);
    return a ^ 32'h8000_0413;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] wm);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (wm[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Expected memory contents, updated as stimulus is issued.
  logic [31:0] shadow [logic [31:0]];
  txn_t ifu_q[$];
  txn_t lsu_q[$];

  function automatic logic [31:0] shadow_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : base_word(a);
  endfunction

  // Memory slave: one-cycle response, programmable request stall.
  logic [31:0] memstore [logic [31:0]];
  int stall_cnt = 0;

  initial begin
    logic hs_req, hs_resp, rst_s, w;
    logic [31:0] a, d;
    logic [3:0] m;
    mem_if.req_ready  = 1'b0;
    mem_if.resp_valid = 1'b0;
    mem_if.resp_data  = '0;
    forever begin
      @(negedge clk);
      rst_s   = rst;
      hs_req  = mem_if.req_valid && mem_if.req_ready;
      hs_resp = mem_if.resp_valid && mem_if.resp_ready;
      a = mem_if.req_addr; d = mem_if.req_wdata; m = mem_if.req_wmask; w = mem_if.req_wen;
      if (mem_if.req_valid && !mem_if.req_ready && stall_cnt > 0) stall_cnt--;
      @(posedge clk); #1;
      if (!rst_s) begin
        mem_if.resp_valid = 1'b0;
        mem_if.resp_data  = '0;
      end else begin
        if (hs_resp) begin
          mem_if.resp_valid = 1'b0;
          mem_if.resp_data  = '0;
        end
        if (hs_req) begin
          if (w) begin
            memstore[a] = merge(memstore.exists(a) ? memstore[a] : base_word(a), d, m);
            mem_if.resp_data = '0;
          end else begin
            mem_if.resp_data = memstore.exists(a) ? memstore[a] : base_word(a);
          end
          mem_if.resp_valid = 1'b1;
        end
      end
      mem_if.req_ready = (stall_cnt == 0);
    end
  end

  // Master response-ready: held low for *_hold cycles of a pending response.
  int ifu_hold = 0;
  int lsu_hold = 0;

  initial begin
    ifu_if.resp_ready = 1'b0;
    lsu_if.resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (ifu_if.resp_valid && !ifu_if.resp_ready && ifu_hold > 0) ifu_hold--;
      if (lsu_if.resp_valid && !lsu_if.resp_ready && lsu_hold > 0) lsu_hold--;
      @(posedge clk); #1;
      ifu_if.resp_ready = (ifu_hold == 0);
      lsu_if.resp_ready = (lsu_hold == 0);
    end
  end

  // Reference model of the arbiter, stepped at each falling edge.
  arb_state_e m_st   = ST_IDLE;
  mid_t       m_own  = MID_IFU;
  mid_t       m_last = MID_IFU;
  txn_t       cur;
  logic       chk_en = 1'b0;
  int         cyc = 0;
  int         ifu_resp_n = 0;
  int         lsu_resp_n = 0;
  int         grant_cyc = 0;
  int         resp_cyc = 0;
  mid_t       glog[$];
  int         gcyc[$];

  function automatic mid_t exp_win(input logic vi, input logic vl);
    if (vi && vl) begin
`ifdef MEM_ARB_RR_EN
      return (m_last == MID_IFU) ? MID_LSU : MID_IFU;
`else
      return MID_LSU;
`endif
    end
    return vl ? MID_LSU : MID_IFU;
  endfunction

  initial begin
    logic vi, vl, rr;
    mid_t w;
    forever begin
      @(negedge clk);
      cyc++;
      vi = ifu_if.req_valid;
      vl = lsu_if.req_valid;
      w  = exp_win(vi, vl);
      rr = (m_own == MID_LSU) ? lsu_if.resp_ready : ifu_if.resp_ready;
      if (chk_en) begin
        check_eq("busy", 32'(busy), 32'(m_st != ST_IDLE));
        check_eq("mem_req_valid", 32'(mem_if.req_valid), 32'(m_st == ST_REQ));
        case (m_st)
          ST_IDLE: begin
            check_eq("ifu_req_ready", 32'(ifu_if.req_ready), 32'(vi && (w == MID_IFU)));
            check_eq("lsu_req_ready", 32'(lsu_if.req_ready), 32'(vl && (w == MID_LSU)));
            check_eq("idle_mem_resp_ready", 32'(mem_if.resp_ready), 32'd0);
            check_eq("idle_ifu_resp_valid", 32'(ifu_if.resp_valid), 32'd0);
            check_eq("idle_lsu_resp_valid", 32'(lsu_if.resp_valid), 32'd0);
          end
          ST_REQ: begin
            check_eq("req_addr", mem_if.req_addr, cur.addr);
            check_eq("req_wdata", mem_if.req_wdata, cur.wdata);
            check_eq("req_wmask", 32'(mem_if.req_wmask), 32'(cur.wmask));
            check_eq("req_wen", 32'(mem_if.req_wen), 32'(cur.wen));
            check_eq("req_ifu_ready", 32'(ifu_if.req_ready), 32'd0);
            check_eq("req_lsu_ready", 32'(lsu_if.req_ready), 32'd0);
            check_eq("req_mem_resp_ready", 32'(mem_if.resp_ready), 32'd0);
          end
          default: begin
            check_eq("mem_resp_ready", 32'(mem_if.resp_ready), 32'(rr));
            if (m_own == MID_LSU) begin
              check_eq("lsu_resp_valid", 32'(lsu_if.resp_valid), 32'(mem_if.resp_valid));
              check_eq("ifu_resp_valid_nonowner", 32'(ifu_if.resp_valid), 32'd0);
              check_eq("ifu_resp_data_nonowner", ifu_if.resp_data, 32'd0);
              if (mem_if.resp_valid) check_eq("lsu_resp_data", lsu_if.resp_data, mem_if.resp_data);
            end else begin
              check_eq("ifu_resp_valid", 32'(ifu_if.resp_valid), 32'(mem_if.resp_valid));
              check_eq("lsu_resp_valid_nonowner", 32'(lsu_if.resp_valid), 32'd0);
              check_eq("lsu_resp_data_nonowner", lsu_if.resp_data, 32'd0);
              if (mem_if.resp_valid) check_eq("ifu_resp_data", ifu_if.resp_data, mem_if.resp_data);
            end
            if (mem_if.resp_valid && rr && !cur.wen)
              check_eq("sb_rdata", (m_own == MID_LSU) ? lsu_if.resp_data : ifu_if.resp_data,
                       cur.rdata);
          end
        endcase
      end
      if (!rst) begin
        m_st   = ST_IDLE;
        m_own  = MID_IFU;
        m_last = MID_IFU;
        chk_en = 1'b1;
      end else if (chk_en) begin
        case (m_st)
          ST_IDLE: begin
            if (vi || vl) begin
              if (w == MID_LSU && lsu_q.size() > 0) cur = lsu_q.pop_front();
              else if (w == MID_IFU && ifu_q.size() > 0) cur = ifu_q.pop_front();
              else check_eq("sb_underflow", 32'd1, 32'd0);
              m_own = w;
              glog.push_back(w);
              gcyc.push_back(cyc);
              grant_cyc = cyc;
              m_st = ST_REQ;
            end
          end
          ST_REQ: if (mem_if.req_ready) m_st = ST_RESP;
          default: begin
            if (mem_if.resp_valid && rr) begin
              m_last = m_own;
              resp_cyc = cyc;
              if (m_own == MID_LSU) lsu_resp_n++;
              else ifu_resp_n++;
              m_st = ST_IDLE;
            end
          end
        endcase
      end
    end
  end

  task automatic ifu_send(input logic [31:0] a);
    txn_t t;
    logic got;
    t.addr = a; t.wdata = '0; t.wmask = '0; t.wen = 1'b0; t.rdata = shadow_rd(a);
    ifu_q.push_back(t);
    @(posedge clk); #1;
    ifu_if.req_valid = 1'b1;
    ifu_if.req_addr  = a;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifu_if.req_ready) begin got = 1'b1; break; end
    end
    if (!got) check_eq("ifu_req_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    ifu_if.req_valid = 1'b0;
  endtask

  task automatic lsu_send(input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] wm, input logic we);
    txn_t t;
    logic got;
    t.addr = a; t.wdata = wd; t.wmask = wm; t.wen = we; t.rdata = shadow_rd(a);
    if (we) shadow[a] = merge(shadow_rd(a), wd, wm);
    lsu_q.push_back(t);
    @(posedge clk); #1;
    lsu_if.req_valid = 1'b1;
    lsu_if.req_addr  = a;
    lsu_if.req_wdata = wd;
    lsu_if.req_wmask = wm;
    lsu_if.req_wen   = we;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (lsu_if.req_ready) begin got = 1'b1; break; end
    end
    if (!got) check_eq("lsu_req_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    lsu_if.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (m_st == ST_IDLE && !ifu_if.req_valid && !lsu_if.req_valid &&
          ifu_q.size() == 0 && lsu_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check_eq("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n0, g0;
    mid_t exp_seq [3];
    logic got;
    rst = 1'b0;
    ifu_if.req_valid = 1'b0; ifu_if.req_addr = '0; ifu_if.req_wdata = '0;
    ifu_if.req_wmask = '0;   ifu_if.req_wen  = 1'b0;
    lsu_if.req_valid = 1'b0; lsu_if.req_addr = '0; lsu_if.req_wdata = '0;
    lsu_if.req_wmask = '0;   lsu_if.req_wen  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_mem_req_valid", 32'(mem_if.req_valid), 32'd0);
    check_eq("rst_mem_req_addr", mem_if.req_addr, 32'd0);
    check_eq("rst_mem_req_wdata", mem_if.req_wdata, 32'd0);
    check_eq("rst_mem_req_wmask", 32'(mem_if.req_wmask), 32'd0);
    check_eq("rst_mem_req_wen", 32'(mem_if.req_wen), 32'd0);
    check_eq("rst_mem_resp_ready", 32'(mem_if.resp_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // IFU fetch: grant T, memory request T+1, response T+2.
    ifu_send(32'h8000_0000);
    wait_idle();
    check_eq("ifu_latency", 32'(resp_cyc - grant_cyc), 32'd2);
    check_eq("ifu_resp_count", 32'(ifu_resp_n), 32'd1);
    check_eq("lsu_resp_quiet", 32'(lsu_resp_n), 32'd0);

    // LSU store, then IFU reads it back.
    lsu_send(32'h8000_0100, 32'hDEAD_BEEF, 4'hF, 1'b1);
    wait_idle();
    check_eq("lsu_store_resp_count", 32'(lsu_resp_n), 32'd1);
    lsu_send(32'h8000_0104, 32'h1234_5678, 4'h3, 1'b1);
    lsu_send(32'h8000_0104, 32'h0, 4'h0, 1'b0);
    ifu_send(32'h8000_0100);
    wait_idle();

    // Three simultaneous IFU+LSU rounds.
    g0 = glog.size();
    fork
      ifu_send(32'h8000_0008);
      begin
        lsu_send(32'h8000_0200, 32'h0, 4'h0, 1'b0);
        lsu_send(32'h8000_0204, 32'h0, 4'h0, 1'b0);
        lsu_send(32'h8000_0208, 32'h0, 4'h0, 1'b0);
      end
    join
    wait_idle();
`ifdef MEM_ARB_RR_EN
    exp_seq[0] = MID_LSU; exp_seq[1] = MID_IFU; exp_seq[2] = MID_LSU;
`else
    exp_seq[0] = MID_LSU; exp_seq[1] = MID_LSU; exp_seq[2] = MID_LSU;
`endif
    check_eq("tie_grant_count", 32'(glog.size() - g0), 32'd4);
    if (glog.size() >= g0 + 3) begin
      for (int k = 0; k < 3; k++) check_eq($sformatf("tie_grant%0d", k),
                                           32'(glog[g0+k]), 32'(exp_seq[k]));
      check_eq("grant_spacing", 32'(gcyc[g0+1] - gcyc[g0]), 32'd3);
    end

    // Memory request stalled 4 cycles, then response held off 3 cycles.
    stall_cnt = 4;
    ifu_send(32'h8000_0010);
    wait_idle();
    check_eq("stall_latency", 32'(resp_cyc - grant_cyc), 32'd6);
    n0 = ifu_resp_n;
    ifu_hold = 3;
    ifu_send(32'h8000_0014);
    wait_idle();
    check_eq("hold_single_hs", 32'(ifu_resp_n - n0), 32'd1);
    check_eq("hold_latency", 32'(resp_cyc - grant_cyc), 32'd5);

    // Reset while the response is pending.
    n0 = ifu_resp_n;
    ifu_hold = 1000;
    ifu_send(32'h8000_0040);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (m_st == ST_RESP) begin got = 1'b1; break; end
    end
    if (!got) check_eq("resp_wait_timeout", 32'd0, 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    ifu_hold = 0;
    @(negedge clk);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_mem_req_valid", 32'(mem_if.req_valid), 32'd0);
    check_eq("mid_rst_mem_resp_ready", 32'(mem_if.resp_ready), 32'd0);
    check_eq("mid_rst_ifu_resp_valid", 32'(ifu_if.resp_valid), 32'd0);
    check_eq("mid_rst_ifu_req_ready", 32'(ifu_if.req_ready), 32'd0);
    check_eq("mid_rst_lsu_req_ready", 32'(lsu_if.req_ready), 32'd0);
    check_eq("mid_rst_no_hs", 32'(ifu_resp_n - n0), 32'd0);
    ifu_send(32'h8000_0044);
    wait_idle();
    check_eq("post_rst_hs", 32'(ifu_resp_n - n0), 32'd1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
